formula_result_buffer: RTL and testbench

Credit-based result buffer that sits directly downstream of the `formula_2_pipe` stage and adds backpressure to it. The pipeline has a fixed latency and cannot be stalled, so this block decides when a new argument set may be issued. It admits an issue only when a FIFO slot is guaranteed for the result, captures every `res_vld`/`res` beat, and presents results on a valid/ready interface to the consumer.

---
 rtl/formula_result_buffer_if.sv | 27 ++
 rtl/formula_result_buffer.sv | 94 +++++++++
 tb/tb_formula_result_buffer.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/formula_result_buffer_if.sv
// formula_result_buffer_if: request, pipe-result and consumer handshakes.
// master drives the producer/pipe/consumer side; slave is the buffer.
interface formula_result_buffer_if #(
    parameter int width = 32,
    parameter int depth = 64
);
    logic                   req_vld;
    logic                   req_rdy;
    logic                   arg_vld;
    logic                   res_vld;
    logic [width-1:0]       res;
    logic                   out_vld;
    logic                   out_rdy;
    logic [width-1:0]       out_data;
    logic [$clog2(depth):0] level;
    logic                   err;

    modport master (
        output req_vld, res_vld, res, out_rdy,
        input  req_rdy, arg_vld, out_vld, out_data, level, err
    );

    modport slave (
        input  req_vld, res_vld, res, out_rdy,
        output req_rdy, arg_vld, out_vld, out_data, level, err
    );
endinterface

// File: rtl/formula_result_buffer.sv
// formula_result_buffer: credit-gated result FIFO behind formula_2_pipe.
// Define FORMULA_RESULT_BUFFER_CHECK_EN to add the pipe-latency checker.
module formula_result_buffer #(
    parameter int width   = 32,
    parameter int depth   = 64,
    parameter int latency = 50
) (
    input logic clk,
    input logic rst,
    formula_result_buffer_if.slave bus
);
    localparam int aw = $clog2(depth);
    localparam int lw = aw + 1;

    if (depth < 2 || (depth & (depth - 1)) != 0 || latency < 1) begin : g_bad_cfg
        $error("formula_result_buffer: depth must be a power of two >= 2, latency >= 1");
    end

    logic [width-1:0] mem [depth];
    logic [aw-1:0]    wr_ptr;
    logic [aw-1:0]    rd_ptr;
    logic [lw-1:0]    count;
    logic [lw-1:0]    in_flight;
    logic [lw-1:0]    committed;
    logic             rdy;
    logic             issue;
    logic             push;
    logic             pop;
    logic             unexp;
    logic             chk_err;
    logic             out_vld;
    logic             err_q;

    // Credits come from registered counters only, so a pop frees a slot next cycle.
    assign committed = count + in_flight;
    assign rdy       = rst & (committed < lw'(depth));
    assign issue     = bus.req_vld & rdy;
    assign out_vld   = (count != '0);
    assign pop       = out_vld & bus.out_rdy;
    assign push      = bus.res_vld & (in_flight != '0);
    assign unexp     = bus.res_vld & (in_flight == '0);

    assign bus.req_rdy  = rdy;
    assign bus.arg_vld  = issue;
    assign bus.out_vld  = out_vld;
    assign bus.out_data = out_vld ? mem[rd_ptr] : '0;
    assign bus.level    = committed;
    assign bus.err      = err_q;

`ifdef FORMULA_RESULT_BUFFER_CHECK_EN
    logic [latency-1:0] iss_sr;

    // Bit latency-1 holds the issue made exactly latency cycles ago.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_sr <= '0;
        end else begin
            iss_sr <= latency'({iss_sr, issue});
        end
    end

    assign chk_err = bus.res_vld ^ iss_sr[latency-1];
`else
    assign chk_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.res;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= '0;
            in_flight <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            err_q     <= 1'b0;
        end else begin
            count     <= count + lw'(push) - lw'(pop);
            in_flight <= in_flight + lw'(issue) - lw'(push);
            if (push) begin
                wr_ptr <= wr_ptr + aw'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + aw'(1);
            end
            if (unexp | chk_err) begin
                err_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_formula_result_buffer.sv
// tb_formula_result_buffer: random traffic through a modelled fixed-latency
// pipe, checked against a queue-based reference of the buffer.
module tb_formula_result_buffer;
    localparam int W = 32;
    localparam int D = 64;
    localparam int L = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    formula_result_buffer_if #(.width(W), .depth(D)) bus ();

    formula_result_buffer #(.width(W), .depth(D), .latency(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit         sched_v [256];
    logic [W-1:0] sched_d [256];
    bit         hist [256];
    logic [W-1:0] q [$];
    int         committed = 0;
    int         n_iss     = 0;
    int         n_pop     = 0;
    int         offset    = L;
    bit         m_err     = 1'b0;
    bit         inj_vld   = 1'b0;
    logic [W-1:0] inj_d   = '0;

    bit         e_rdy, e_arg, e_ov, e_err;
    int         e_level;
    logic [W-1:0] e_head;
    logic       s_rdy, s_arg, s_ov, s_err;
    logic [6:0] s_level;
    logic [W-1:0] s_od;

    task automatic model_reset();
        q.delete();
        committed = 0;
        m_err     = 1'b0;
        inj_vld   = 1'b0;
        for (int i = 0; i < 256; i++) begin
            sched_v[i] = 1'b0;
            hist[i]    = 1'b0;
        end
    endtask

    // One clock: drive pipe results, sample, derive expectations, advance model.
    task automatic cycle();
        int slot;
        bit iss, pop, rv, unexp;
        slot = cyc % 256;
        bus.res_vld = inj_vld | sched_v[slot];
        bus.res     = inj_vld ? inj_d : sched_d[slot];
        sched_v[slot] = 1'b0;
        @(negedge clk);
        s_rdy   = bus.req_rdy;
        s_arg   = bus.arg_vld;
        s_ov    = bus.out_vld;
        s_od    = bus.out_data;
        s_level = bus.level;
        s_err   = bus.err;
        e_rdy   = rst && (committed < D);
        e_arg   = bus.req_vld && e_rdy;
        e_ov    = (q.size() > 0);
        e_head  = e_ov ? q[0] : '0;
        e_level = committed;
        e_err   = m_err;
        if (rst) begin
            iss   = e_arg;
            pop   = e_ov && bus.out_rdy;
            rv    = bus.res_vld;
            unexp = rv && (committed == q.size());
`ifdef FORMULA_RESULT_BUFFER_CHECK_EN
            if (rv != hist[(cyc + 256 - L) % 256]) m_err = 1'b1;
`endif
            if (unexp) m_err = 1'b1;
            if (pop) begin
                void'(q.pop_front());
                n_pop++;
            end
            if (rv && !unexp) q.push_back(bus.res);
            hist[slot] = iss;
            if (iss) begin
                sched_v[(cyc + offset) % 256] = 1'b1;
                sched_d[(cyc + offset) % 256] = $urandom;
                n_iss++;
            end
            committed += int'(iss) - int'(pop);
        end
        @(posedge clk);
        #1;
        cyc++;
        inj_vld = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        bus.req_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (s_arg !== 1'b0 || s_rdy !== 1'b0)
                $display("FAIL reset_hs arg_vld=%b req_rdy=%b want 0/0", s_arg, s_rdy);
            if (s_arg !== 1'b0 || s_rdy !== 1'b0) n_fail++;
            n_checks++;
            if (s_ov !== 1'b0 || s_od !== '0 || s_level !== 7'd0 || s_err !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_out out_vld=%b out_data=%h level=%0d err=%b want zeros",
                         s_ov, s_od, s_level, s_err);
            end
        end
        rst = 1'b1;
        bus.req_vld = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        bus.req_vld = 1'b0;
        bus.out_rdy = 1'b1;
        while (committed > 0 && k < 400) begin
            cycle();
            k++;
            n_checks++;
            if (s_ov !== e_ov || (e_ov && s_od !== e_head)) begin
                n_fail++;
                $display("FAIL drain_out out_vld=%b data=%h want %b/%h", s_ov, s_od, e_ov, e_head);
            end
        end
        cycle();
        n_checks++;
        if (s_level !== 7'd0 || s_ov !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_done level=%0d out_vld=%b want 0/0", s_level, s_ov);
        end
    endtask

    task automatic test_reset();
        bus.out_rdy = 1'b0;
        bus.res_vld = 1'b0;
        bus.res     = '0;
        do_reset();
        bus.req_vld = 1'b1;
        cycle();
        n_checks++;
        if (s_rdy !== 1'b1 || s_level !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_release req_rdy=%b level=%0d want 1/0", s_rdy, s_level);
        end
        drain();
    endtask

    task automatic test_streaming();
        int first_iss, first_out, iss0, pop0, k;
        first_iss = -1;
        first_out = -1;
        iss0 = n_iss;
        pop0 = n_pop;
        bus.out_rdy = 1'b1;
        bus.req_vld = 1'b1;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (first_iss < 0 && s_arg === 1'b1) first_iss = cyc - 1;
            if (first_out < 0 && s_ov === 1'b1) first_out = cyc - 1;
            n_checks++;
            if (s_rdy !== 1'b1 || s_arg !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_rdy req_rdy=%b arg_vld=%b want 1/1", s_rdy, s_arg);
            end
            n_checks++;
            if (s_ov !== e_ov || (e_ov && s_od !== e_head)) begin
                n_fail++;
                $display("FAIL stream_out out_vld=%b data=%h want %b/%h", s_ov, s_od, e_ov, e_head);
            end
        end
        k = 0;
        bus.req_vld = 1'b0;
        while (committed > 0 && k < 200) begin
            cycle();
            k++;
            n_checks++;
            if (s_ov !== e_ov || (e_ov && s_od !== e_head)) begin
                n_fail++;
                $display("FAIL stream_tail out_vld=%b data=%h want %b/%h", s_ov, s_od, e_ov, e_head);
            end
        end
        n_checks++;
        if (first_out - first_iss != 51) begin
            n_fail++;
            $display("FAIL stream_latency got %0d want 51", first_out - first_iss);
        end
        n_checks++;
        if (n_iss - iss0 != 200 || n_pop - pop0 != 200 || s_err !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_totals iss=%0d pop=%0d err=%b want 200/200/0",
                     n_iss - iss0, n_pop - pop0, s_err);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int dut_iss;
        dut_iss = 0;
        bus.out_rdy = 1'b0;
        bus.req_vld = 1'b1;
        for (int i = 0; i < 120; i++) begin
            cycle();
            if (s_arg === 1'b1) dut_iss++;
            n_checks++;
            if (s_rdy !== e_rdy || s_level !== 7'(e_level)) begin
                n_fail++;
                $display("FAIL bp_fill req_rdy=%b level=%0d want %b/%0d", s_rdy, s_level, e_rdy, e_level);
            end
        end
        n_checks++;
        if (dut_iss != 64 || s_level !== 7'd64 || s_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full issues=%0d level=%0d req_rdy=%b want 64/64/0", dut_iss, s_level, s_rdy);
        end
        bus.out_rdy = 1'b1;
        cycle();
        n_checks++;
        if (s_rdy !== 1'b0 || s_ov !== 1'b1 || s_od !== e_head) begin
            n_fail++;
            $display("FAIL bp_pop req_rdy=%b out_vld=%b data=%h want 0/1/%h", s_rdy, s_ov, s_od, e_head);
        end
        bus.out_rdy = 1'b0;
        cycle();
        n_checks++;
        if (s_rdy !== 1'b1 || s_arg !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_credit req_rdy=%b arg_vld=%b want 1/1", s_rdy, s_arg);
        end
        cycle();
        n_checks++;
        if (s_rdy !== 1'b0 || s_level !== 7'd64) begin
            n_fail++;
            $display("FAIL bp_refill req_rdy=%b level=%0d want 0/64", s_rdy, s_level);
        end
        drain();
    endtask

    task automatic test_stall();
        int pop0, k;
        pop0 = n_pop;
        k = 0;
        bus.req_vld = 1'b1;
        while (n_pop - pop0 < 500 && k < 3000) begin
            bus.out_rdy = (k % 2 == 0);
            cycle();
            k++;
            n_checks++;
            if (s_ov !== e_ov || (e_ov && s_od !== e_head) || s_rdy !== e_rdy) begin
                n_fail++;
                $display("FAIL stall_out out_vld=%b data=%h req_rdy=%b want %b/%h/%b",
                         s_ov, s_od, s_rdy, e_ov, e_head, e_rdy);
            end
        end
        n_checks++;
        if (n_pop - pop0 < 500) begin
            n_fail++;
            $display("FAIL stall_timeout pops=%0d want 500", n_pop - pop0);
        end
        drain();
    endtask

    task automatic test_random();
        bus.out_rdy = 1'b0;
        for (int i = 0; i < 800; i++) begin
            bus.req_vld = ($urandom_range(0, 3) != 0);
            bus.out_rdy = ($urandom_range(0, 2) != 0);
            cycle();
            n_checks++;
            if (s_rdy !== e_rdy || s_arg !== e_arg || s_level !== 7'(e_level)) begin
                n_fail++;
                $display("FAIL rand_credit req_rdy=%b arg_vld=%b level=%0d want %b/%b/%0d",
                         s_rdy, s_arg, s_level, e_rdy, e_arg, e_level);
            end
            n_checks++;
            if (s_ov !== e_ov || (e_ov && s_od !== e_head) || s_err !== e_err) begin
                n_fail++;
                $display("FAIL rand_out out_vld=%b data=%h err=%b want %b/%h/%b",
                         s_ov, s_od, s_err, e_ov, e_head, e_err);
            end
        end
        drain();
    endtask

    task automatic test_unexpected();
        bus.out_rdy = 1'b0;
        bus.req_vld = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        bus.req_vld = 1'b0;
        for (int i = 0; i < 55; i++) cycle();
        n_checks++;
        if (s_err !== 1'b0 || s_level !== 7'd3) begin
            n_fail++;
            $display("FAIL unexp_pre err=%b level=%0d want 0/3", s_err, s_level);
        end
        inj_vld = 1'b1;
        inj_d   = 32'hDEADBEEF;
        cycle();
        for (int i = 0; i < 6; i++) begin
            cycle();
            n_checks++;
            if (s_err !== 1'b1 || s_level !== 7'd3 || s_ov !== 1'b1 || s_od !== e_head) begin
                n_fail++;
                $display("FAIL unexp_post err=%b level=%0d out_vld=%b data=%h want 1/3/1/%h",
                         s_err, s_level, s_ov, s_od, e_head);
            end
        end
        bus.req_vld = 1'b1;
        for (int i = 0; i < 10; i++) cycle();
    endtask

    task automatic test_check();
        bit want;
`ifdef FORMULA_RESULT_BUFFER_CHECK_EN
        want = 1'b1;
`else
        want = 1'b0;
`endif
        do_reset();
        bus.out_rdy = 1'b1;
        cycle();
        n_checks++;
        if (s_err !== 1'b0 || s_level !== 7'd0) begin
            n_fail++;
            $display("FAIL midreset_clear err=%b level=%0d want 0/0", s_err, s_level);
        end
        offset = L - 1;
        bus.req_vld = 1'b1;
        cycle();
        bus.req_vld = 1'b0;
        offset = L;
        for (int i = 0; i < 60; i++) cycle();
        n_checks++;
        if (s_err !== want || s_err !== e_err) begin
            n_fail++;
            $display("FAIL check_early err=%b want %b", s_err, want);
        end
        n_checks++;
        if (s_level !== 7'd0 || s_ov !== 1'b0) begin
            n_fail++;
            $display("FAIL check_drain level=%0d out_vld=%b want 0/0", s_level, s_ov);
        end
    endtask

    initial begin
        bus.req_vld = 1'b0;
        bus.res_vld = 1'b0;
        bus.res     = '0;
        bus.out_rdy = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_stall();
        test_random();
        test_unexpected();
        test_check();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
